// File: rtl/alu_exec_unit.sv
// Execution-stage ALU: single-cycle logic/arithmetic ops plus a 32-step
// iterative signed shift-add multiplier feeding Hi/Lo, with Start/Busy/Done handshake.
module alu_exec_unit #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Start,
   input  logic [3:0]       AluS,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic [WIDTH-1:0] Result,
   output logic             Zero,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo,
   output logic             Busy,
   output logic             Done
);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_MULT = 4'b0011;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;

   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic {S_IDLE, S_MUL} state_t;

   state_t             state, state_nxt;
   logic [WIDTH-1:0]   mcand, mplier, acc;
   logic               neg;
   logic [CNT_W-1:0]   cnt;

   logic               accept_single, accept_mul, mul_last;
   logic [WIDTH-1:0]   alu_res, abs_a, abs_b;
   logic [WIDTH:0]     addend, step_sum;
   logic [2*WIDTH-1:0] step_prod, final_prod;

   // State register
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE: if (Start && AluS == OP_MULT) state_nxt = S_MUL;
         S_MUL:  if (cnt == LAST_ITER)         state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // FSM output decode
   always_comb begin
      accept_single = 1'b0;
      accept_mul    = 1'b0;
      mul_last      = 1'b0;
      Busy          = 1'b0;
      unique case (state)
         S_IDLE: begin
            accept_single = Start && (AluS != OP_MULT);
            accept_mul    = Start && (AluS == OP_MULT);
         end
         S_MUL: begin
            Busy     = 1'b1;
            mul_last = (cnt == LAST_ITER);
         end
         default: ;
      endcase
   end

   // Single-cycle result
   always_comb begin
      alu_res = '0;
      unique case (AluS)
         OP_AND: alu_res = A & B;
         OP_OR:  alu_res = A | B;
         OP_ADD: alu_res = A + B;
         OP_SUB: alu_res = A - B;
         OP_SLT: alu_res[0] = ($signed(A) < $signed(B));
         default: alu_res = '0;
      endcase
   end

   // Magnitudes; the most negative value maps to itself, read as unsigned
   assign abs_a = A[WIDTH-1] ? -A : A;
   assign abs_b = B[WIDTH-1] ? -B : B;

   // One shift-add step; the last step's output is folded straight into Hi/Lo
   assign addend     = mplier[0] ? {1'b0, mcand} : '0;
   assign step_sum   = {1'b0, acc} + addend;
   assign step_prod  = {step_sum, mplier[WIDTH-1:1]};
   assign final_prod = neg ? -step_prod : step_prod;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         Result <= '0;
         Zero   <= 1'b1;
         Hi     <= '0;
         Lo     <= '0;
         Done   <= 1'b0;
         mcand  <= '0;
         mplier <= '0;
         acc    <= '0;
         neg    <= 1'b0;
         cnt    <= '0;
      end else begin
         Done <= 1'b0;
         if (accept_single) begin
            Result <= alu_res;
            Zero   <= (alu_res == '0);
            Done   <= 1'b1;
         end else if (accept_mul) begin
            mcand  <= abs_a;
            mplier <= abs_b;
            acc    <= '0;
            neg    <= A[WIDTH-1] ^ B[WIDTH-1];
            cnt    <= '0;
         end else if (state == S_MUL) begin
            acc    <= step_sum[WIDTH:1];
            mplier <= {step_sum[0], mplier[WIDTH-1:1]};
            cnt    <= cnt + CNT_W'(1);
            if (mul_last) begin
               Hi     <= final_prod[2*WIDTH-1:WIDTH];
               Lo     <= final_prod[WIDTH-1:0];
               Result <= final_prod[WIDTH-1:0];
               Zero   <= (final_prod[WIDTH-1:0] == '0);
               Done   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: vector table for single-cycle
// ops plus hand-written multiply, busy-ignore and mid-multiply reset sequences.
module tb_alu_exec_unit;

   localparam int unsigned W = 32;

   logic         Clk, Rst_n, Start;
   logic [3:0]   AluS;
   logic [W-1:0] A, B, Result, Hi, Lo;
   logic         Zero, Busy, Done;

   int n_chk  = 0;
   int n_fail = 0;

   alu_exec_unit #(.WIDTH(W), .CNT_W(6)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .AluS(AluS), .A(A), .B(B),
      .Result(Result), .Zero(Zero), .Hi(Hi), .Lo(Lo), .Busy(Busy), .Done(Done)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string      name;
      logic [3:0] op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic        zero;
   } vec_t;

   vec_t vecs[11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_result"}, Result, 32'h0);
      chk({tag, "_zero"}, 32'(Zero), 32'd1);
      chk({tag, "_hi"}, Hi, 32'h0);
      chk({tag, "_lo"}, Lo, 32'h0);
      chk({tag, "_busy"}, 32'(Busy), 32'd0);
      chk({tag, "_done"}, 32'(Done), 32'd0);
   endtask

   // Runs a full multiply; optionally scrambles inputs and holds Start while busy
   task automatic run_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input bit disturb, input logic [31:0] ehi, input logic [31:0] elo);
      @(negedge Clk);
      Start = 1'b1; AluS = 4'b0011; A = a; B = b;
      @(posedge Clk); #1;
      chk({tag, "_accept_busy"}, {30'b0, Busy, Done}, 32'b10);
      for (int i = 1; i <= int'(W); i++) begin
         @(negedge Clk);
         if (disturb) begin
            Start = 1'b1; AluS = 4'b0010; A = $urandom; B = $urandom;
         end else begin
            Start = 1'b0;
         end
         @(posedge Clk); #1;
         if (i < int'(W))
            chk({tag, "_iter_busy"}, {30'b0, Busy, Done}, 32'b10);
      end
      chk({tag, "_done_busy"}, {30'b0, Busy, Done}, 32'b01);
      chk({tag, "_hi"}, Hi, ehi);
      chk({tag, "_lo"}, Lo, elo);
      chk({tag, "_result"}, Result, elo);
      chk({tag, "_zero"}, 32'(Zero), 32'(elo == 32'h0));
      @(negedge Clk);
      Start = 1'b0;
      @(posedge Clk); #1;
      chk({tag, "_done_drop"}, 32'(Done), 32'd0);
      chk({tag, "_hi_hold"}, Hi, ehi);
   endtask

   initial begin
      vecs[0]  = '{"and",      4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0};
      vecs[1]  = '{"or",       4'b0001, 32'hF0000000, 32'h0000000F, 32'hF000000F, 1'b0};
      vecs[2]  = '{"add_wrap", 4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1};
      vecs[3]  = '{"sub_eq",   4'b0110, 32'h00000005, 32'h00000005, 32'h00000000, 1'b1};
      vecs[4]  = '{"slt_neg",  4'b0111, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b0};
      vecs[5]  = '{"slt_pos",  4'b0111, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, 1'b1};
      vecs[6]  = '{"slt_ext",  4'b0111, 32'h7FFFFFFF, 32'h80000000, 32'h00000000, 1'b1};
      vecs[7]  = '{"sub_neg",  4'b0110, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1'b0};
      vecs[8]  = '{"add",      4'b0010, 32'h12345678, 32'h11111111, 32'h23456789, 1'b0};
      vecs[9]  = '{"op0100",   4'b0100, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1};
      vecs[10] = '{"op1111",   4'b1111, 32'hDEADBEEF, 32'h12345678, 32'h00000000, 1'b1};

      Rst_n = 1'b0; Start = 1'b0; AluS = 4'b0; A = '0; B = '0;
      repeat (2) @(posedge Clk);
      #1 check_reset_vals("reset");
      @(negedge Clk) Rst_n = 1'b1;

      // Isolated ADD: Done for exactly one cycle
      @(negedge Clk);
      Start = 1'b1; AluS = 4'b0010; A = 32'd7; B = 32'd5;
      @(posedge Clk); #1;
      chk("add_result", Result, 32'd12);
      chk("add_zero", 32'(Zero), 32'd0);
      chk("add_done_busy", {30'b0, Busy, Done}, 32'b01);
      @(negedge Clk) Start = 1'b0;
      @(posedge Clk); #1;
      chk("add_done_drop", 32'(Done), 32'd0);
      chk("add_result_hold", Result, 32'd12);

      // Back-to-back single-cycle vectors, Start held high
      foreach (vecs[i]) begin
         @(negedge Clk);
         Start = 1'b1; AluS = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
         @(posedge Clk); #1;
         chk({vecs[i].name, "_result"}, Result, vecs[i].res);
         chk({vecs[i].name, "_zero"}, 32'(Zero), 32'(vecs[i].zero));
         chk({vecs[i].name, "_done_busy"}, {30'b0, Busy, Done}, 32'b01);
      end
      @(negedge Clk) Start = 1'b0;
      @(posedge Clk); #1;
      chk("table_done_drop", 32'(Done), 32'd0);

      run_mult("mul_m3x7", 32'hFFFFFFFD, 32'd7, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);

      // Undefined op leaves Hi/Lo alone
      @(negedge Clk);
      Start = 1'b1; AluS = 4'b1111; A = 32'h5; B = 32'h9;
      @(posedge Clk); #1;
      chk("undef_result", Result, 32'h0);
      chk("undef_zero", 32'(Zero), 32'd1);
      chk("undef_done", 32'(Done), 32'd1);
      chk("undef_hi", Hi, 32'hFFFFFFFF);
      chk("undef_lo", Lo, 32'hFFFFFFEB);
      @(negedge Clk) Start = 1'b0;
      @(posedge Clk); #1;
      chk("undef_done_drop", 32'(Done), 32'd0);

      run_mult("mul_min", 32'h80000000, 32'h80000000, 1'b1, 32'h40000000, 32'h00000000);
      run_mult("mul_mixed", 32'h00010003, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFF, 32'hFFFDFFFA);

      // Reset during iteration 10 of a multiply
      @(negedge Clk);
      Start = 1'b1; AluS = 4'b0011; A = 32'd5; B = 32'd6;
      @(posedge Clk);
      @(negedge Clk) Start = 1'b0;
      repeat (10) @(posedge Clk);
      #2 Rst_n = 1'b0;
      #1 check_reset_vals("midreset");
      @(negedge Clk) Rst_n = 1'b1;
      @(negedge Clk);
      Start = 1'b1; AluS = 4'b0010; A = 32'd1; B = 32'd2;
      @(posedge Clk); #1;
      chk("post_rst_add", Result, 32'd3);
      chk("post_rst_hi", Hi, 32'h0);
      chk("post_rst_lo", Lo, 32'h0);
      @(negedge Clk) Start = 1'b0;
      repeat (40) @(posedge Clk);
      #1;
      chk("post_rst_idle_busy", 32'(Busy), 32'd0);
      chk("post_rst_lo_late", Lo, 32'h0);
      chk("post_rst_result_hold", Result, 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
